// File: rtl/mux_n_pipe_pkg.sv
// Shared definitions for the registered N-input multiplexer:
// default parameter values and the buffer state encoding.
package mux_n_pipe_pkg;

  localparam int DEF_WIDTH  = 32;
  localparam int DEF_NUM_IN = 4;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } buf_state_t;

endpackage

// File: rtl/mux_n_comb.sv
// Combinational word selection from a packed input vector, with
// out-of-range select detection (bad selects fall back to input 0).
module mux_n_comb
  import mux_n_pipe_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int NUM_IN = DEF_NUM_IN,
  parameter int SEL_W  = $clog2(NUM_IN)
) (
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]        sel,
  output logic [WIDTH-1:0]        word,
  output logic                    sel_bad
);

  assign sel_bad = (32'(sel) >= 32'(NUM_IN));

  // NOTE: assigning a default before the loop keeps every path driven, so no latch is inferred.
  always_comb begin
    word = in_data[0 +: WIDTH];
    for (int k = 1; k < NUM_IN; k++) begin
      if (32'(sel) == k) word = in_data[k*WIDTH +: WIDTH];
    end
  end

endmodule

// File: rtl/mux_n_pipe.sv
// N-input multiplexer feeding a two-entry skid buffer with valid/ready
// handshakes on both sides; in_ready is registered to break ready paths.
module mux_n_pipe
  import mux_n_pipe_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int NUM_IN = DEF_NUM_IN,
  parameter int SEL_W  = $clog2(NUM_IN)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]        sel,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  input  logic                    flush,
  output logic                    sel_err
);

  buf_state_t       state, state_nxt;
  logic [WIDTH-1:0] main_data, skid_data;
  logic [WIDTH-1:0] word;
  logic             sel_bad;
  logic             accept, pop;
  logic             load_main, load_skid, skid_to_main;

  mux_n_comb #(
    .WIDTH  (WIDTH),
    .NUM_IN (NUM_IN),
    .SEL_W  (SEL_W)
  ) u_sel (
    .in_data (in_data),
    .sel     (sel),
    .word    (word),
    .sel_bad (sel_bad)
  );

  assign out_valid = (state != ST_EMPTY);
  assign out_data  = main_data;
  assign accept    = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_comb begin
    state_nxt    = state;
    load_main    = 1'b0;
    load_skid    = 1'b0;
    skid_to_main = 1'b0;
    unique case (state)
      ST_EMPTY: if (accept) begin
        state_nxt = ST_ONE;
        load_main = 1'b1;
      end
      ST_ONE: begin
        if (accept && pop) begin
          load_main = 1'b1;
        end else if (accept) begin
          state_nxt = ST_FULL;
          load_skid = 1'b1;
        end else if (pop) begin
          state_nxt = ST_EMPTY;
        end
      end
      ST_FULL: if (pop) begin
        state_nxt    = ST_ONE;
        skid_to_main = 1'b1;
      end
      default: state_nxt = ST_EMPTY;
    endcase
    // Flush wins over any same-cycle accept or pop.
    if (flush) begin
      state_nxt    = ST_EMPTY;
      load_main    = 1'b0;
      load_skid    = 1'b0;
      skid_to_main = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_EMPTY;
      in_ready <= 1'b1;
      sel_err  <= 1'b0;
    end else begin
      state    <= state_nxt;
      in_ready <= (state_nxt != ST_FULL);
      if (flush)                sel_err <= 1'b0;
      else if (accept && sel_bad) sel_err <= 1'b1;
    end
  end

  // NOTE: the two data registers are cleared on reset so out_data is defined before the first word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_data <= '0;
      skid_data <= '0;
    end else begin
      if (load_main)         main_data <= word;
      else if (skid_to_main) main_data <= skid_data;
      if (load_skid)         skid_data <= word;
    end
  end

endmodule

// File: tb/tb_mux_n_pipe.sv
// Directed checks of mux_n_pipe on three parameterisations plus a
// randomised valid/ready run scored against a FIFO of accepted words.
module tb_mux_n_pipe;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Default instance: NUM_IN=4, WIDTH=32.
  logic [127:0] a_in_data;
  logic [1:0]   a_sel;
  logic         a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_flush, a_sel_err;
  logic [31:0]  a_out_data;

  mux_n_pipe dut (
    .clk (clk), .rst (rst), .in_data (a_in_data), .sel (a_sel),
    .in_valid (a_in_valid), .in_ready (a_in_ready), .out_data (a_out_data),
    .out_valid (a_out_valid), .out_ready (a_out_ready), .flush (a_flush),
    .sel_err (a_sel_err)
  );

  // Non-power-of-two instance: NUM_IN=5, WIDTH=32.
  logic [159:0] b_in_data;
  logic [2:0]   b_sel;
  logic         b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_flush, b_sel_err;
  logic [31:0]  b_out_data;

  mux_n_pipe #(.WIDTH(32), .NUM_IN(5)) dut5 (
    .clk (clk), .rst (rst), .in_data (b_in_data), .sel (b_sel),
    .in_valid (b_in_valid), .in_ready (b_in_ready), .out_data (b_out_data),
    .out_valid (b_out_valid), .out_ready (b_out_ready), .flush (b_flush),
    .sel_err (b_sel_err)
  );

  // Wide-select instance: NUM_IN=16, WIDTH=8.
  logic [127:0] r_in_data;
  logic [3:0]   r_sel;
  logic         r_in_valid, r_in_ready, r_out_valid, r_out_ready, r_flush, r_sel_err;
  logic [7:0]   r_out_data;

  mux_n_pipe #(.WIDTH(8), .NUM_IN(16)) dut16 (
    .clk (clk), .rst (rst), .in_data (r_in_data), .sel (r_sel),
    .in_valid (r_in_valid), .in_ready (r_in_ready), .out_data (r_out_data),
    .out_valid (r_out_valid), .out_ready (r_out_ready), .flush (r_flush),
    .sel_err (r_sel_err)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [7:0] sb[$];
  logic [7:0] exp_b;
  logic       acc, pp;

  initial begin
    rst = 1'b1;
    a_in_data = '0; a_sel = '0; a_in_valid = 0; a_out_ready = 0; a_flush = 0;
    b_in_data = '0; b_sel = '0; b_in_valid = 0; b_out_ready = 0; b_flush = 0;
    r_in_data = '0; r_sel = '0; r_in_valid = 0; r_out_ready = 0; r_flush = 0;
    #1;
    check("rst_out_valid", a_out_valid, 1'b0);
    check("rst_in_ready", a_in_ready, 1'b1);
    check("rst_out_data", a_out_data, 32'h0);
    check("rst_sel_err", b_sel_err, 1'b0);
    repeat (2) tick();
    rst = 1'b0;

    // Latency-1 select of input 2.
    a_out_ready = 1;
    a_in_data = {32'h33333333, 32'hDEADBEEF, 32'h11111111, 32'h00000000};
    a_sel = 2'd2; a_in_valid = 1;
    tick();
    a_in_valid = 0;
    check("lat1_valid", a_out_valid, 1'b1);
    check("lat1_data", a_out_data, 32'hDEADBEEF);
    tick();
    check("drain_valid", a_out_valid, 1'b0);
    check("hold_data_idle", a_out_data, 32'hDEADBEEF);

    // Fill to FULL with backpressure, then drain in order.
    a_out_ready = 0; a_sel = 2'd0;
    a_in_data = 128'h1; a_in_valid = 1;
    tick();
    check("one_in_ready", a_in_ready, 1'b1);
    a_in_data = 128'h2;
    tick();
    a_in_valid = 0;
    check("full_in_ready", a_in_ready, 1'b0);
    check("full_head", a_out_data, 32'h1);
    tick();
    check("stall_valid", a_out_valid, 1'b1);
    check("stall_data", a_out_data, 32'h1);
    a_out_ready = 1;
    tick();
    check("pop1_data", a_out_data, 32'h2);
    check("pop1_in_ready", a_in_ready, 1'b1);
    tick();
    check("pop2_valid", a_out_valid, 1'b0);

    // ONE with simultaneous accept and pop replaces main.
    a_in_data = {96'h0, 32'hA0A0A0A0}; a_in_valid = 1;
    tick();
    a_in_data = {96'h0, 32'hB1B1B1B1};
    tick();
    a_in_valid = 0;
    check("swap_data", a_out_data, 32'hB1B1B1B1);
    check("swap_in_ready", a_in_ready, 1'b1);
    tick();
    check("swap_drain", a_out_valid, 1'b0);

    // Flush from FULL with in_valid held high.
    a_out_ready = 0;
    a_in_data = 128'h11; a_in_valid = 1;
    tick();
    a_in_data = 128'h22;
    tick();
    check("pre_flush_in_ready", a_in_ready, 1'b0);
    a_in_data = 128'h33; a_flush = 1;
    tick();
    a_flush = 0; a_in_valid = 0; a_out_ready = 1;
    check("flush_valid", a_out_valid, 1'b0);
    check("flush_in_ready", a_in_ready, 1'b1);
    tick();
    check("flush_no_output", a_out_valid, 1'b0);

    // Asynchronous reset between edges while FULL.
    a_out_ready = 0;
    a_in_data = 128'h44; a_in_valid = 1;
    tick();
    a_in_data = 128'h55;
    tick();
    a_in_valid = 0;
    check("pre_rst_full", a_in_ready, 1'b0);
    #3 rst = 1'b1;
    #1;
    check("async_rst_valid", a_out_valid, 1'b0);
    check("async_rst_in_ready", a_in_ready, 1'b1);
    check("async_rst_data", a_out_data, 32'h0);
    rst = 1'b0;
    #1;
    a_in_data = 128'h66; a_in_valid = 1;
    tick();
    a_in_valid = 0;
    check("post_rst_valid", a_out_valid, 1'b1);
    check("post_rst_data", a_out_data, 32'h66);

    // Out-of-range select on the 5-input instance.
    b_out_ready = 1;
    b_in_data = {32'hBB, 96'h0, 32'hAA};
    b_sel = 3'd4; b_in_valid = 1;
    tick();
    check("sel4_data", b_out_data, 32'hBB);
    check("sel4_err", b_sel_err, 1'b0);
    b_sel = 3'd7;
    tick();
    b_in_valid = 0;
    check("sel7_data", b_out_data, 32'hAA);
    check("sel7_err", b_sel_err, 1'b1);
    repeat (2) tick();
    check("sel_err_sticky", b_sel_err, 1'b1);
    b_flush = 1;
    tick();
    b_flush = 0;
    check("sel_err_flush", b_sel_err, 1'b0);

    // Randomised valid/ready traffic on the 16-input instance.
    for (int c = 0; c < 10000; c++) begin
      r_in_data = {$urandom, $urandom, $urandom, $urandom};
      r_sel = 4'($urandom);
      r_in_valid = ($urandom % 4) != 0;
      r_out_ready = ($urandom % 2) != 0;
      #1;
      check("rnd_out_valid", r_out_valid, sb.size() != 0);
      check("rnd_in_ready", r_in_ready, sb.size() < 2);
      acc = r_in_valid && r_in_ready;
      pp = r_out_valid && r_out_ready;
      if (pp && sb.size() != 0) begin
        exp_b = sb.pop_front();
        check("rnd_data", r_out_data, exp_b);
      end
      if (acc) begin
        exp_b = r_in_data[r_sel*8 +: 8];
        sb.push_back(exp_b);
      end
      tick();
    end
    r_in_valid = 0; r_out_ready = 1;
    for (int c = 0; c < 4 && sb.size() != 0; c++) begin
      #1;
      if (r_out_valid) begin
        exp_b = sb.pop_front();
        check("drain_data", r_out_data, exp_b);
      end else begin
        check("drain_stuck", r_out_valid, 1'b1);
      end
      tick();
    end
    check("rnd_sb_empty", sb.size(), 0);
    check("rnd_final_valid", r_out_valid, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
